mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the CPU data-bus port (port B), downstream of the pipeline's store/load path.
- Stores to its address window enqueue bytes into a small FIFO. An FSM serialises them as 8N1 frames on `tx`.
- Loads return status with the same one-cycle synchronous read latency as the main memory.
- A top-level decoder uses `hit` to steer store-enable and select the load data.

Parameters:
- BASE_ADDR, 32'hFFFF_0000: base of the 16-byte register window; must be 16-byte aligned.
- FIFO_DEPTH, 8: byte FIFO entries; power of two, 2..64.
- DIV_RESET, 16'd434: reset value of the baud divisor, in clk cycles per bit.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- b_addr  in  32  byte address from the ALU result.
- b_we  in  1  store strobe, already qualified by pipeline validity.
- b_in  in  32  store data.
- b_out  out  32  registered load data.
- hit  out  1  combinational: b_addr[31:4] == BASE_ADDR[31:4].
- tx  out  1  serial output, idle high, registered.
- irq  out  1  registered: IRQ_EN bit and FIFO empty and FSM idle.

Behaviour:
- Reset (async): FIFO empty, pointers 0, FSM IDLE, tx=1, b_out=0, irq=0, DIV=DIV_RESET, IRQ_EN=0, OVF=0.
- Register map; offset = b_addr[3:2], b_addr[1:0] ignored:
  - 0x0 DATA: write pushes b_in[7:0]; reads 0.
  - 0x4 STATUS (read): bit0 full, bit1 empty, bit2 busy (FSM != IDLE), bit3 OVF, bits[10:4] count; rest 0. Any write clears OVF.
  - 0x8 DIV: R/W bits[15:0]; upper bits read 0.
  - 0xC CTRL: R/W bit0 IRQ_EN.
- Writes take effect at the edge where b_we & hit are sampled.
- Reads: b_out at edge N+1 reflects registers and FIFO state as they were before edge N+1, for the b_addr presented in cycle N.
- When hit=0, b_out is loaded with 0.
- No read side effects.
- FIFO push: b_we & hit & offset 0 & !full.
  - Push while full: byte dropped, OVF set. Full is evaluated before any same-edge pop, so a simultaneous pop does not admit the push.
  - Count is FIFO_DEPTH at full. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if !empty, pop the head into the shift register, load the baud counter, go to START, tx<=0.
  - START: after DIV cycles, go to DATA with bit index 0, tx<=shift[0].
  - DATA: every DIV cycles shift right and increment the index. The edge ending the bit-7 period goes to STOP with tx<=1.
  - STOP: after DIV cycles go to IDLE. If the FIFO is non-empty at that edge, go directly to START: pop, tx<=0, giving back-to-back frames.
- Baud counter: loaded with max(DIV,1)-1 on each bit entry, decrements each cycle, and a bit ends at 0.
  - DIV=0 behaves as 1.
  - A DIV write mid-frame affects only the next counter reload.
- Frame length is exactly 10*max(DIV,1) cycles. Bit order: LSB first.
- A push into an empty FIFO while IDLE: the FSM pops at the next edge. tx falls on the second edge after the write edge.
- rst asserted mid-frame: tx returns high immediately and the queued bytes are discarded.

Test Plan:
- Reset, then read STATUS -> b_out = 0x0000_0002 one cycle later; tx=1, irq=0.
- Write DIV=4, then DATA=0x55 -> tx low 2 edges after the write for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles; busy=1 throughout, 0 after.
- DIV=1, write 0xA5 then 0x3C in consecutive cycles -> two back-to-back 10-cycle frames with no idle cycle between; bits are LSB first.
- DIV=100, push 9 bytes with FIFO_DEPTH=8 -> 1st pop frees a slot, so 9th accepted if pushed after the pop. Pushing 9 before any pop -> STATUS bit3=1, count=8. Write STATUS -> OVF=0.
- Read 0x8 after reset -> 0x0000_01B2. Read an address outside the window (0x0000_0010) -> hit=0, b_out=0. Write to 0xC with IRQ_EN=1 while idle and empty -> irq=1 next edge.
- Assert rst at bit 3 of a frame with 3 bytes queued -> tx=1 immediately, STATUS=0x2 after release, no further frames.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: a byte FIFO fed by bus stores, drained by a
// serialiser FSM, with status/divisor/control registers read back through b_out.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] b_addr,
    input  logic        b_we,
    input  logic [31:0] b_in,
    output logic [31:0] b_out,
    output logic        hit,
    output logic        tx,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   div_q, div_d, cnt_q, cnt_d, reload;
    logic          irq_en_q, irq_en_d, ovf_q, ovf_d;
    state_t        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d, irq_q, irq_d;
    logic [31:0]   b_out_q, b_out_d;
    logic [1:0]    off;
    logic          full, empty, busy, wr_hit, push, pop;
    logic [6:0]    count_ext;
    logic          unused_bits;

    assign hit         = (b_addr[31:4] == BASE_ADDR[31:4]);
    assign off         = b_addr[3:2];
    assign full        = (count_q == CW'(FIFO_DEPTH));
    assign empty       = (count_q == '0);
    assign busy        = (state_q != S_IDLE);
    assign wr_hit      = b_we & hit;
    assign push        = wr_hit & (off == 2'd0) & ~full;
    assign count_ext   = 7'(count_q);
    // DIV=0 is treated as one cycle per bit
    assign reload      = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;
    assign unused_bits = ^{b_addr[1:0], b_in[31:16]};

    // Serialiser; tx is registered from the current state, so the line lags the FSM by one edge
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_q[rd_ptr_q];
                    cnt_d   = reload;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == 16'd0) begin
                    state_d = S_DATA;
                    idx_d   = 3'd0;
                    cnt_d   = reload;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == 16'd0) begin
                    cnt_d = reload;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (cnt_q == 16'd0) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_q[rd_ptr_q];
                        cnt_d   = reload;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        unique case (state_q)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
        irq_d = irq_en_q & empty & (state_q == S_IDLE);
    end

    // Register writes, FIFO bookkeeping and read mux
    always_comb begin
        div_d    = div_q;
        irq_en_d = irq_en_q;
        ovf_d    = ovf_q;
        if (wr_hit) begin
            unique case (off)
                2'd0: if (full) ovf_d = 1'b1;
                2'd1: ovf_d = 1'b0;
                2'd2: div_d = b_in[15:0];
                2'd3: irq_en_d = b_in[0];
                default: ;
            endcase
        end

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);

        b_out_d = 32'd0;
        if (hit) begin
            unique case (off)
                2'd1:    b_out_d = {21'd0, count_ext, ovf_q, busy, empty, full};
                2'd2:    b_out_d = {16'd0, div_q};
                2'd3:    b_out_d = {31'd0, irq_en_q};
                default: b_out_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= b_in[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            div_q    <= DIV_RESET;
            irq_en_q <= 1'b0;
            ovf_q    <= 1'b0;
            state_q  <= S_IDLE;
            cnt_q    <= 16'd0;
            idx_q    <= 3'd0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
            irq_q    <= 1'b0;
            b_out_q  <= 32'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            div_q    <= div_d;
            irq_en_q <= irq_en_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            irq_q    <= irq_d;
            b_out_q  <= b_out_d;
        end
    end

    assign tx    = tx_q;
    assign irq   = irq_q;
    assign b_out = b_out_q;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register map, frame timing, back-to-back frames,
// FIFO overflow and mid-frame reset.
module tb_mmio_uart_tx;
    localparam logic [31:0] A_DATA = 32'hFFFF_0000;
    localparam logic [31:0] A_STAT = 32'hFFFF_0004;
    localparam logic [31:0] A_DIV  = 32'hFFFF_0008;
    localparam logic [31:0] A_CTRL = 32'hFFFF_000C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] b_addr = 32'd0;
    logic        b_we = 1'b0;
    logic [31:0] b_in = 32'd0;
    logic [31:0] b_out;
    logic        hit, tx, irq;

    int vecs = 0;
    int errs = 0;

    mmio_uart_tx dut (
        .clk(clk), .rst(rst), .b_addr(b_addr), .b_we(b_we), .b_in(b_in),
        .b_out(b_out), .hit(hit), .tx(tx), .irq(irq)
    );

    always #5 clk = ~clk;

    // All tasks start and end at a falling edge.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        b_addr = addr; b_in = data; b_we = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        b_addr = addr; b_we = 1'b0;
        @(posedge clk);
        @(negedge clk);
        data = b_out;
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s got=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; b_we = 1'b0; b_addr = 32'd0; b_in = 32'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // k counts edges after the first DATA write edge; tx falls at k=2
    task automatic check_tx(input string name, input logic [15:0] bytes, input int n,
                            input int div, input int k0);
        logic e;
        int j, f, p;
        for (int k = k0; k <= 2 + n * 10 * div + 2; k++) begin
            e = 1'b1;
            if (k >= 2) begin
                j = k - 2;
                f = j / (10 * div);
                p = (j % (10 * div)) / div;
                if (f < n) begin
                    if (p == 0)      e = 1'b0;
                    else if (p <= 8) e = bytes[f*8 + p - 1];
                end
            end
            vecs++;
            if (tx !== e) begin
                errs++;
                $display("FAIL %s k=%0d tx=%b expected=%b", name, k, tx, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        @(negedge clk);
        vecs++;
        if (tx !== 1'b1 || irq !== 1'b0 || b_out !== 32'd0) begin
            errs++;
            $display("FAIL reset_outputs tx=%b irq=%b b_out=0x%08h expected 1 0 0", tx, irq, b_out);
        end
        rst = 1'b0;
        @(negedge clk);
        rd(A_STAT, d);
        chk32("reset_status", d, 32'h2);
        vecs++;
        if (tx !== 1'b1 || irq !== 1'b0) begin
            errs++;
            $display("FAIL reset_idle tx=%b irq=%b expected 1 0", tx, irq);
        end
    endtask

    task automatic test_regs();
        logic [31:0] d;
        rd(A_DIV, d);
        chk32("div_reset", d, 32'h0000_01B2);
        chk32("hit_in_window", {31'd0, hit}, 32'd1);
        rd(32'h0000_0010, d);
        chk32("hit_outside", {31'd0, hit}, 32'd0);
        chk32("read_outside", d, 32'd0);
        rd(A_DATA, d);
        chk32("read_data_reg", d, 32'd0);
        wr(A_DIV, 32'h1234_5678);
        rd(32'hFFFF_000B, d);
        chk32("div_rw_low_bits_ignored", d, 32'h0000_5678);
        wr(A_CTRL, 32'h1);
        @(negedge clk);
        chk32("irq_after_enable", {31'd0, irq}, 32'd1);
        rd(A_CTRL, d);
        chk32("ctrl_read", d, 32'd1);
    endtask

    task automatic test_frame();
        logic [31:0] d;
        wr(A_DIV, 32'd4);
        wr(A_DATA, 32'h55);
        check_tx("frame_55_div4", 16'h0055, 1, 4, 0);
        rd(A_STAT, d);
        chk32("status_after_frame", d, 32'h2);
    endtask

    task automatic test_back_to_back();
        wr(A_DIV, 32'd1);
        wr(A_DATA, 32'hA5);
        wr(A_DATA, 32'h3C);
        check_tx("b2b_a5_3c_div1", 16'h3CA5, 2, 1, 1);
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        wr(A_DIV, 32'd100);
        for (int i = 0; i < 9; i++) wr(A_DATA, 32'h10 + i);
        rd(A_STAT, d);
        chk32("status_full_no_ovf", d, 32'h85);
        wr(A_DATA, 32'hEE);
        rd(A_STAT, d);
        chk32("status_ovf", d, 32'h8D);
        wr(A_STAT, 32'h0);
        rd(A_STAT, d);
        chk32("status_ovf_cleared", d, 32'h85);
        repeat (1000) @(negedge clk);
        rd(A_STAT, d);
        chk32("status_after_2nd_pop", d, 32'h74);
        wr(A_DATA, 32'h77);
        rd(A_STAT, d);
        chk32("status_refill_no_ovf", d, 32'h85);
        do_reset();
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d;
        wr(A_DIV, 32'd4);
        wr(A_DATA, 32'h11);
        wr(A_DATA, 32'h22);
        wr(A_DATA, 32'h33);
        wr(A_DATA, 32'h44);
        repeat (16) @(negedge clk);
        chk32("tx_low_in_bit3", {31'd0, tx}, 32'd0);
        rst = 1'b1;
        #1;
        vecs++;
        if (tx !== 1'b1 || irq !== 1'b0 || b_out !== 32'd0) begin
            errs++;
            $display("FAIL midframe_reset tx=%b irq=%b b_out=0x%08h expected 1 0 0", tx, irq, b_out);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd(A_STAT, d);
        chk32("status_after_midframe_reset", d, 32'h2);
        rd(A_DIV, d);
        chk32("div_after_midframe_reset", d, 32'h1B2);
        for (int k = 0; k < 100; k++) begin
            vecs++;
            if (tx !== 1'b1) begin
                errs++;
                $display("FAIL no_frame_after_reset k=%0d tx=%b expected=1", k, tx);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_frame();
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
